register_file_param: RTL
========================

REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, register and data width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 4, number of registers (2..256).
REQ-003 The block SHALL have parameter ADDR_W, default 2, select width, with 2**ADDR_W >= NUM_REGS.
REQ-004 The block SHALL have parameter IMM_W, default 3, immediate width (1..DATA_W).
REQ-005 The block SHALL have parameter IMM_SIGNED, default 0; 1 = sign-extend imm, 0 = zero-extend.
REQ-006 The block SHALL have port CLK, input, 1, the only clock; all state updates on its rising edge.
REQ-007 The block SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port rd, input, ADDR_W, destination/read-port-A select.
REQ-009 The block SHALL have port rs, input, ADDR_W, source/read-port-B select.
REQ-010 The block SHALL have port regSelect, input, 1, write enable for register rd.
REQ-011 The block SHALL have port immSelect, input, 1, substitutes extended imm on rd_data.
REQ-012 The block SHALL have port imm, input, IMM_W, immediate operand.
REQ-013 The block SHALL have port write_data, input, DATA_W, write value.
REQ-014 The block SHALL have port rd_data, output, DATA_W, immSelect ? ext(imm) : reg[rd].
REQ-015 The block SHALL have port rs_data, output, DATA_W, reg[rs].
REQ-016 The block SHALL have port storeData, output, DATA_W, reg[rd] regardless of immSelect.
REQ-017 The block SHALL have port rd_valid, output, 1, reg[rd] written since reset.
REQ-018 The block SHALL have port rs_valid, output, 1, reg[rs] written since reset.
REQ-019 The block SHALL have port wr_count, output, 16, number of accepted writes since reset.

Function
REQ-020 Reads SHALL be combinational, zero-latency, from the current register contents.
REQ-021 On rising CLK with regSelect=1 and rd < NUM_REGS, reg[rd] SHALL take write_data and valid[rd] SHALL set; the new value SHALL be visible on the read ports in the following cycle.
REQ-022 A write SHALL increment wr_count by 1; wr_count SHALL saturate at 16'hFFFF.
REQ-023 Select values >= NUM_REGS SHALL read as 0 with valid 0, and writes to them SHALL be ignored without incrementing wr_count.
REQ-024 ext(imm) SHALL replicate imm[IMM_W-1] into the upper bits when IMM_SIGNED=1, else zero-fill; IMM_W=DATA_W SHALL pass imm through unchanged.
REQ-025 immSelect SHALL affect only rd_data; it SHALL NOT block a simultaneous write.
REQ-026 rd=rs SHALL return identical register data on rs_data and storeData.

Reset
REQ-027 RST_N=0 SHALL immediately clear every register, every valid bit and wr_count, independent of CLK.
REQ-028 During reset rs_data, storeData, rd_valid, rs_valid and wr_count SHALL be 0; rd_data SHALL be 0 unless immSelect=1 (then ext(imm)).
REQ-029 A write coinciding with RST_N=0 SHALL be discarded; a reset asserted mid-sequence SHALL lose all prior writes.
REQ-030 The first write SHALL be accepted on the first rising CLK after RST_N deasserts.

Configuration
REQ-031 With macro REGFILE_BYPASS_EN defined, a read whose select equals rd while regSelect=1 (and rd < NUM_REGS) SHALL return write_data combinationally, with valid 1, in the same cycle.
REQ-032 Without REGFILE_BYPASS_EN, such a read SHALL return the pre-write contents until after the clock edge.

Verification
REQ-033 Reset, then read rs=0, rs=1 -> rs_data=8'h00, rs_valid=0, wr_count=0.
REQ-034 Write 8'h07 to rd=0, then 8'h03 to rd=1; read rd=0, rs=1 -> rd_data=8'h07, rs_data=8'h03, both valid=1, wr_count=2.
REQ-035 immSelect=1, imm=3'b100, rd=0 holding 8'h07 -> rd_data=8'h04 (IMM_SIGNED=0) or 8'hFC (IMM_SIGNED=1); storeData=8'h07.
REQ-036 regSelect=1, rd=2, rs=2, write_data=8'hA5, sampled before the edge -> rs_data=8'hA5 with REGFILE_BYPASS_EN, 8'h00 without; after the edge 8'hA5 in both builds.
REQ-037 NUM_REGS=3: write 8'h55 to rd=3 -> reads of select 3 return 8'h00, valid 0, wr_count unchanged.
REQ-038 After writes, pulse RST_N low between clock edges -> all outputs 0 immediately; a write held across the reset pulse is not stored.

Source files
------------

// File: rtl/register_file_param.sv
// Parameterized register file: two combinational read ports, one write port, immediate
// substitution on rd_data, per-register written-since-reset flags and a saturating write counter.
// Optional macro REGFILE_BYPASS_EN forwards the in-flight write to matching reads in the same cycle.

module register_file_param_cell #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o,
  output logic              vld_o
);
  logic [DATA_W-1:0] data_q;
  logic              vld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (we_i) begin
      data_q <= d_i;
      vld_q  <= 1'b1;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;
endmodule

module register_file_param #(
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_W     = 2,
  parameter int IMM_W      = 3,
  parameter bit IMM_SIGNED = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic              regSelect,
  input  logic              immSelect,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] storeData,
  output logic              rd_valid,
  output logic              rs_valid,
  output logic [15:0]       wr_count
);
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] reg_q;
  logic [NUM_REGS-1:0]             vld_q;
  logic [15:0]                     wr_count_q, wr_count_d;
  logic                            wr_ok;
  logic [DATA_W-1:0]               imm_ext;
  logic [DATA_W-1:0]               rd_reg, rs_reg;
  logic                            rd_v, rs_v;

  // Out-of-range selects never write, so they also never count.
  assign wr_ok = regSelect && ({1'b0, rd} < NREGS);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    register_file_param_cell #(.DATA_W(DATA_W)) u_cell (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .we_i   (wr_ok && (rd == ADDR_W'(g))),
      .d_i    (write_data),
      .q_o    (reg_q[g]),
      .vld_o  (vld_q[g])
    );
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_ok && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) wr_count_q <= '0;
    else        wr_count_q <= wr_count_d;
  end

  if (IMM_W == DATA_W) begin : g_imm_full
    assign imm_ext = imm;
  end else if (IMM_SIGNED) begin : g_imm_sext
    assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  end else begin : g_imm_zext
    assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
  end

  always_comb begin
    rd_reg = '0;
    rd_v   = 1'b0;
    rs_reg = '0;
    rs_v   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd == ADDR_W'(i)) begin
        rd_reg = reg_q[i];
        rd_v   = vld_q[i];
      end
      if (rs == ADDR_W'(i)) begin
        rs_reg = reg_q[i];
        rs_v   = vld_q[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    // A write held during reset is discarded, so it must not be forwarded either.
    if (wr_ok && RST_N) begin
      rd_reg = write_data;
      rd_v   = 1'b1;
      if (rs == rd) begin
        rs_reg = write_data;
        rs_v   = 1'b1;
      end
    end
`endif
  end

  assign rd_data   = immSelect ? imm_ext : rd_reg;
  assign storeData = rd_reg;
  assign rs_data   = rs_reg;
  assign rd_valid  = rd_v;
  assign rs_valid  = rs_v;
  assign wr_count  = wr_count_q;
endmodule
